// File: rtl/fpu_arbiter_pkg.sv
// Shared FPU definitions: opcode encoding and bus widths used by the
// arbiter, its tag FIFO and the requester/FPU interface.
package fpu_arbiter_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 32;

  // Opcodes 5..7 are not named but still travel through the arbiter untouched.
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_SQRT = 3'd4
  } fpu_op_e;

  // Index width that stays legal when only one entry exists.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_arbiter_if.sv
// Requester and FPU bus bundle. The master side is the system (requesters
// plus FPU), the slave side is the arbiter.
interface fpu_arbiter_if
  import fpu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][OP_W-1:0]   req_op;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [DATA_W-1:0]              resp_result;

  logic                           fpu_start;
  logic [OP_W-1:0]                fpu_op;
  logic [DATA_W-1:0]              fpu_operand_a;
  logic [DATA_W-1:0]              fpu_operand_b;
  logic                           fpu_stall;
  logic                           fpu_valid;
  logic [DATA_W-1:0]              fpu_result;

  modport master (
    output req_valid, req_op, req_a, req_b, fpu_stall, fpu_valid, fpu_result,
    input  req_ready, resp_valid, resp_result,
           fpu_start, fpu_op, fpu_operand_a, fpu_operand_b
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, fpu_stall, fpu_valid, fpu_result,
    output req_ready, resp_valid, resp_result,
           fpu_start, fpu_op, fpu_operand_a, fpu_operand_b
  );
endinterface

// File: rtl/fpu_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each in-flight FPU op.
module fpu_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  import fpu_arbiter_pkg::*;

  localparam int AW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy update; push and pop in one cycle leave count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Tag storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one pipelined FPU among NUM_REQ requesters.
// Grants issue combinationally, in-flight owners are tracked in a tag FIFO,
// and each FPU result is routed back one cycle later through a register.
module fpu_arbiter
  import fpu_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  fpu_arbiter_if.slave               bus,
  output logic [$clog2(TAG_DEPTH):0] outstanding,
  output logic                       tag_underflow
);
  localparam int IDX_W = clog2_min1(NUM_REQ);

  logic [IDX_W-1:0] rr_ptr, gnt_idx, tag_head;
  logic             any_req, issue, pop, full, empty;

  // Round-robin search from rr_ptr for the first requester with valid high.
  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    gnt_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (!any_req && bus.req_valid[IDX_W'(idx)]) begin
        any_req = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
  end

  // Full is taken from the pre-pop count, so a full FIFO never issues even
  // when a result is returning in the same cycle.
  assign issue = any_req & ~bus.fpu_stall & ~full & ~reset;
  assign pop   = bus.fpu_valid & ~empty;

  // Issue path: operands flow straight from the granted requester; idle is all zero.
  always_comb begin
    bus.req_ready     = '0;
    bus.fpu_start     = 1'b0;
    bus.fpu_op        = '0;
    bus.fpu_operand_a = '0;
    bus.fpu_operand_b = '0;
    if (issue) begin
      bus.req_ready[gnt_idx] = 1'b1;
      bus.fpu_start          = 1'b1;
      bus.fpu_op             = bus.req_op[gnt_idx];
      bus.fpu_operand_a      = bus.req_a[gnt_idx];
      bus.fpu_operand_b      = bus.req_b[gnt_idx];
    end
  end

  // Round-robin pointer moves past the winner only when an issue happens.
  always_ff @(posedge clk) begin
    if (reset)      rr_ptr <= '0;
    else if (issue) rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  fpu_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (IDX_W)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (issue),
    .din   (gnt_idx),
    .pop   (pop),
    .dout  (tag_head),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

  // Response register: one-cycle pulse to the tag owner, result held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.resp_valid  <= '0;
      bus.resp_result <= '0;
    end else begin
      bus.resp_valid <= '0;
      if (pop) begin
        bus.resp_valid[tag_head] <= 1'b1;
        bus.resp_result          <= bus.fpu_result;
      end
    end
  end

  // A result with nothing in flight is a protocol error; stick until reset.
  always_ff @(posedge clk) begin
    if (reset)                        tag_underflow <= 1'b0;
    else if (bus.fpu_valid && empty)  tag_underflow <= 1'b1;
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: a queue-based reference model of arbitration, tag
// ownership and response routing, plus a fixed-latency in-order FPU model.
module tb_fpu_arbiter;
  import fpu_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int TD = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [$clog2(TD):0] outstanding;
  logic              tag_underflow;

  always #5 clk = ~clk;

  fpu_arbiter_if #(.NUM_REQ(N)) bus ();

  fpu_arbiter #(.NUM_REQ(N), .TAG_DEPTH(TD)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .outstanding   (outstanding),
    .tag_underflow (tag_underflow)
  );

  int          checks = 0, failures = 0;
  int          cyc = 0;
  int          rr_m = 0;
  int          tagq[$];
  bit          uf_m = 0;
  int          fpu_due[$];
  logic [31:0] fpu_res[$];
  int          lat = 4;
  int          fpu_budget = -1;
  bit          inject_valid = 0;
  logic [N-1:0] exp_rv = '0;
  logic [31:0] exp_res = '0;
  logic [31:0] last_resp0 = '0;
  int          n_issue = 0;
  int          grants[$];

  // FPU behaviour: exact for the directed 1.0 + 2.0 case, a fixed mix elsewhere.
  function automatic logic [31:0] fpu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_ADD && a == 32'h3f80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a * 32'd3) ^ {b[15:0], b[31:16]} ^ {29'd0, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive FPU return, check issue path, advance model, check registered outputs.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_ready;
    bit fv;
    logic [31:0] fr;
    bus.fpu_valid  = 1'b0;
    bus.fpu_result = '0;
    if (inject_valid) begin
      bus.fpu_valid  = 1'b1;
      bus.fpu_result = 32'hdead_beef;
    end else if (fpu_due.size() > 0 && fpu_due[0] <= cyc && fpu_budget != 0) begin
      bus.fpu_valid  = 1'b1;
      bus.fpu_result = fpu_res[0];
    end
    #1;
    g = -1;
    if (!reset && !bus.fpu_stall && tagq.size() < TD)
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (rr_m + k) % N;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("fpu_start", 32'(bus.fpu_start), 32'(g >= 0));
    if (g >= 0) begin
      chk("fpu_op", 32'(bus.fpu_op), 32'(bus.req_op[g]));
      chk("fpu_a", bus.fpu_operand_a, bus.req_a[g]);
      chk("fpu_b", bus.fpu_operand_b, bus.req_b[g]);
    end else begin
      chk("fpu_idle_bus", {29'd0, bus.fpu_op} | bus.fpu_operand_a | bus.fpu_operand_b, 32'd0);
    end
    fv = bus.fpu_valid;
    fr = bus.fpu_result;
    @(posedge clk);
    exp_rv = '0;
    if (reset) begin
      tagq.delete();
      fpu_due.delete();
      fpu_res.delete();
      rr_m = 0;
      uf_m = 0;
    end else begin
      if (fv) begin
        if (!inject_valid) begin
          void'(fpu_due.pop_front());
          void'(fpu_res.pop_front());
          if (fpu_budget > 0) fpu_budget--;
        end
        if (tagq.size() > 0) begin
          exp_rv[tagq.pop_front()] = 1'b1;
          exp_res = fr;
        end else uf_m = 1;
      end
      if (g >= 0) begin
        tagq.push_back(g);
        rr_m = (g + 1) % N;
        fpu_due.push_back(cyc + lat);
        fpu_res.push_back(fpu_fn(bus.req_op[g], bus.req_a[g], bus.req_b[g]));
        grants.push_back(g);
        n_issue++;
      end
    end
    cyc++;
    #1;
    chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
    if (exp_rv != '0) chk("resp_result", bus.resp_result, exp_res);
    if (bus.resp_valid[0]) last_resp0 = bus.resp_result;
    chk("outstanding", 32'(outstanding), 32'(tagq.size()));
    chk("tag_underflow", 32'(tag_underflow), 32'(uf_m));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic rand_ops();
    for (int r = 0; r < N; r++) begin
      bus.req_op[r] = 3'($urandom_range(0, 7));
      bus.req_a[r]  = $urandom;
      bus.req_b[r]  = $urandom;
    end
  endtask

  initial begin
    int base;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.fpu_stall = 1'b0;
    bus.fpu_valid = 1'b0;
    bus.fpu_result = '0;
    @(negedge clk);

    // Reset state
    run(2);
    chk("reset_resp_result", bus.resp_result, 32'd0);
    reset = 1'b0;

    // Stalled add from requester 0, then issue and result routing
    bus.req_valid = 2'b01;
    bus.req_op[0] = OP_ADD;
    bus.req_a[0]  = 32'h3f80_0000;
    bus.req_b[0]  = 32'h4000_0000;
    bus.fpu_stall = 1'b1;
    base = n_issue;
    run(3);
    chk("stall_no_issue", 32'(n_issue - base), 32'd0);
    bus.fpu_stall = 1'b0;
    run(1);
    chk("stall_release_issue", 32'(n_issue - base), 32'd1);
    bus.req_valid = '0;
    for (int i = 0; i < 10 && last_resp0 != 32'h4040_0000; i++) cycle();
    chk("add_result_req0", last_resp0, 32'h4040_0000);

    // Both requesters continuously valid: alternating grants from 0
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    grants.delete();
    bus.req_valid = 2'b11;
    for (int i = 0; i < 12; i++) begin rand_ops(); cycle(); end
    bus.req_valid = '0;
    run(8);
    for (int i = 0; i < 8; i++) chk($sformatf("alt_grant%0d", i), 32'(grants[i]), 32'(i % 2));

    // Steady push+pop at outstanding 5
    lat = 5;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin rand_ops(); cycle(); end
    chk("steady_outstanding5", 32'(outstanding), 32'd5);
    rand_ops();
    cycle();
    chk("pushpop_outstanding5", 32'(outstanding), 32'd5);
    bus.req_valid = '0;
    run(10);
    lat = 4;

    // FPU withholds results: FIFO fills to exactly TAG_DEPTH
    fpu_budget = 0;
    base = n_issue;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 20; i++) begin rand_ops(); cycle(); end
    chk("full_issue_count", 32'(n_issue - base), 32'd16);
    chk("full_outstanding", 32'(outstanding), 32'd16);
    fpu_budget = 1;
    base = n_issue;
    cycle();
    chk("full_pop_no_issue", 32'(n_issue - base), 32'd0);
    cycle();
    chk("full_resume_issue", 32'(n_issue - base), 32'd1);
    fpu_budget = -1;
    bus.req_valid = '0;
    run(30);

    // Reset with 7 in flight
    fpu_budget = 0;
    bus.req_valid = 2'b10;
    run(7);
    chk("seven_outstanding", 32'(outstanding), 32'd7);
    reset = 1'b1;
    run(1);
    chk("reset_outstanding", 32'(outstanding), 32'd0);
    chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    reset = 1'b0;
    fpu_budget = -1;
    bus.req_valid = 2'b11;
    run(1);
    chk("rr_after_reset", 32'(grants[$]), 32'd0);
    bus.req_valid = '0;
    run(6);

    // Stray FPU result with nothing issued
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    inject_valid = 1;
    run(1);
    inject_valid = 0;
    run(3);
    chk("underflow_sticky", 32'(tag_underflow), 32'd1);
    reset = 1'b1;
    run(1);
    chk("underflow_cleared", 32'(tag_underflow), 32'd0);
    reset = 1'b0;

    // Random traffic with random stalls and all opcodes
    lat = 3;
    for (int i = 0; i < 300; i++) begin
      bus.req_valid = N'($urandom);
      bus.fpu_stall = ($urandom_range(0, 3) == 0);
      rand_ops();
      cycle();
    end
    bus.req_valid = '0;
    bus.fpu_stall = 1'b0;
    run(20);
    chk("drain_outstanding", 32'(outstanding), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
